// File: rtl/maxnet_seq_cnt.sv
// maxnet_seq_cnt: iteration sequencer for the Maxnet datapath.
// Loads activations, repeatedly kicks the PLU controller and writes results
// back until at most one neuron remains nonzero or MAX_ITER is reached.
// Optional PLU watchdog: define MAXNET_SEQ_WDOG_EN to build it.
module maxnet_seq_cnt #(
    parameter int N_NEURONS   = 4,
    parameter int IDX_W       = 2,
    parameter int MAX_ITER    = 15,
    parameter int ITER_W      = 4,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 plu_done,
    input  logic [N_NEURONS-1:0] nz_flags,
    output logic                 load_we,
    output logic                 plu_start,
    output logic                 act_we,
    output logic                 busy,
    output logic                 done,
    output logic                 winner_valid,
    output logic [IDX_W-1:0]     winner_idx,
    output logic                 timeout,
    output logic [ITER_W-1:0]    iter_cnt,
    output logic                 plu_err
);

    localparam int CNT_W = $clog2(N_NEURONS + 1);

    // Reject parameter sets the counters and index cannot represent.
    generate
        if (N_NEURONS < 2 || (1 << IDX_W) < N_NEURONS || MAX_ITER < 1 ||
            MAX_ITER > (1 << ITER_W) - 1 || WDOG_CYCLES < 1) begin : g_bad_param
            $error("maxnet_seq_cnt: inconsistent parameters");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CHECK, S_KICK, S_WAIT, S_WB, S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [ITER_W-1:0]  iter_cnt_q, iter_cnt_d;
    logic               winner_valid_q, winner_valid_d;
    logic [IDX_W-1:0]   winner_idx_q, winner_idx_d;
    logic               timeout_q, timeout_d;
    logic               plu_err_q, plu_err_d;
    logic               wdog_expired;

    logic [CNT_W-1:0]   nz_cnt;
    logic [IDX_W-1:0]   nz_pos;

    // Population count of surviving neurons and position of a set bit
    // (only meaningful when exactly one bit is set).
    always_comb begin
        nz_cnt = '0;
        nz_pos = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            nz_cnt = nz_cnt + CNT_W'(nz_flags[i]);
            if (nz_flags[i]) nz_pos = IDX_W'(i);
        end
    end

`ifdef MAXNET_SEQ_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;

    // Last WAIT cycle allowed without plu_done; FIN follows on the next edge.
    assign wdog_expired = (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

    // Watchdog cycle counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wdog_q <= '0;
        else      wdog_q <= wdog_d;
    end

    // Cleared in KICK so it starts at zero on entry to WAIT; counts in WAIT.
    always_comb begin
        wdog_d = wdog_q;
        if (state_q == S_KICK)      wdog_d = '0;
        else if (state_q == S_WAIT) wdog_d = wdog_q + WDOG_W'(1);
    end
`else
    assign wdog_expired = 1'b0;
`endif

    // State and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            iter_cnt_q     <= '0;
            winner_valid_q <= 1'b0;
            winner_idx_q   <= '0;
            timeout_q      <= 1'b0;
            plu_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            iter_cnt_q     <= iter_cnt_d;
            winner_valid_q <= winner_valid_d;
            winner_idx_q   <= winner_idx_d;
            timeout_q      <= timeout_d;
            plu_err_q      <= plu_err_d;
        end
    end

    // Next-state and result update logic.
    always_comb begin
        state_d        = state_q;
        iter_cnt_d     = iter_cnt_q;
        winner_valid_d = winner_valid_q;
        winner_idx_d   = winner_idx_q;
        timeout_d      = timeout_q;
        plu_err_d      = plu_err_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: begin
                iter_cnt_d     = '0;
                winner_valid_d = 1'b0;
                winner_idx_d   = '0;
                timeout_d      = 1'b0;
                plu_err_d      = 1'b0;
                state_d        = S_CHECK;
            end
            S_CHECK: begin
                if (nz_cnt == CNT_W'(1)) begin
                    winner_valid_d = 1'b1;
                    winner_idx_d   = nz_pos;
                    state_d        = S_FIN;
                end else if (nz_cnt == '0) begin
                    winner_valid_d = 1'b0;
                    state_d        = S_FIN;
                end else if (iter_cnt_q == ITER_W'(MAX_ITER)) begin
                    timeout_d = 1'b1;
                    state_d   = S_FIN;
                end else begin
                    state_d = S_KICK;
                end
            end
            S_KICK: state_d = S_WAIT;
            S_WAIT: begin
                if (plu_done) begin
                    state_d = S_WB;
                end else if (wdog_expired) begin
                    plu_err_d      = 1'b1;
                    winner_valid_d = 1'b0;
                    timeout_d      = 1'b0;
                    state_d        = S_FIN;
                end
            end
            S_WB: begin
                iter_cnt_d = iter_cnt_q + ITER_W'(1);
                state_d    = S_CHECK;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign load_we      = (state_q == S_LOAD);
    assign plu_start    = (state_q == S_KICK);
    assign act_we       = (state_q == S_WB);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_FIN);
    assign winner_valid = winner_valid_q;
    assign winner_idx   = winner_idx_q;
    assign timeout      = timeout_q;
    assign iter_cnt     = iter_cnt_q;
    assign plu_err      = plu_err_q;

endmodule

// File: tb/tb_maxnet_seq_cnt.sv
// tb_maxnet_seq_cnt: table-driven bench with a result scoreboard for maxnet_seq_cnt.
// Watchdog expectations follow MAXNET_SEQ_WDOG_EN when it is defined.
module tb_maxnet_seq_cnt;

    localparam int N   = 4;
    localparam int PLU = 4;   // PLU model latency from plu_start to plu_done

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         plu_done;
    logic [N-1:0] nz_flags;
    logic         load_we, plu_start, act_we, busy, done, winner_valid, timeout, plu_err;
    logic [1:0]   winner_idx;
    logic [3:0]   iter_cnt;

    maxnet_seq_cnt #(.N_NEURONS(N), .IDX_W(2), .MAX_ITER(15), .ITER_W(4), .WDOG_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .start(start), .plu_done(plu_done), .nz_flags(nz_flags),
        .load_we(load_we), .plu_start(plu_start), .act_we(act_we), .busy(busy), .done(done),
        .winner_valid(winner_valid), .winner_idx(winner_idx), .timeout(timeout),
        .iter_cnt(iter_cnt), .plu_err(plu_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] f0, f1, f2;   // flags at first CHECK, after WB #1, after WB #2 onwards
        int           iters;
        logic         valid;
        logic [1:0]   idx;
        logic         to;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t sb[$];

    // Datapath / PLU model state
    logic [N-1:0] cur_f0 = '0, cur_f1 = '0, cur_f2 = '0;
    logic         plu_en = 1'b1;
    int           wb_cnt, start_cnt, plu_cnt;

    assign nz_flags = (wb_cnt == 0) ? cur_f0 : (wb_cnt == 1) ? cur_f1 : cur_f2;
    assign plu_done = (plu_cnt == 1);

    // Activation-register and PLU behavioural model, plus pulse counters.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_cnt <= 0; start_cnt <= 0; plu_cnt <= 0;
        end else begin
            if (load_we) begin
                wb_cnt <= 0; start_cnt <= 0;
            end else begin
                if (act_we)    wb_cnt    <= wb_cnt + 1;
                if (plu_start) start_cnt <= start_cnt + 1;
            end
            if (plu_start && plu_en) plu_cnt <= PLU;
            else if (plu_cnt != 0)   plu_cnt <= plu_cnt - 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    function automatic int all_out();
        return int'({load_we, plu_start, act_we, busy, done, winner_valid,
                     winner_idx, timeout, iter_cnt, plu_err});
    endfunction

    // Launch one run, wait (bounded) for done, pop expectation and compare.
    task automatic run_vec(input vec_t v);
        vec_t e;
        int   n;
        bit   seen;
        cur_f0 = v.f0; cur_f1 = v.f1; cur_f2 = v.f2;
        sb.push_back(v);
        start = 1'b1;
        seen  = 1'b0;
        n     = 0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            n = c;
            if (c == 1) begin
                start = 1'b0;
                chk("load_we_after_start", int'(load_we), 1);
            end
            if (v.to && c == 50) start = 1'b1;   // ignored while busy
            if (v.to && c == 51) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", int'(seen), 1);
        e = sb.pop_front();
        chk("latency", n, 3 + e.iters * (3 + PLU));
        chk("iter_cnt", int'(iter_cnt), e.iters);
        chk("winner_valid", int'(winner_valid), int'(e.valid));
        if (e.valid) chk("winner_idx", int'(winner_idx), int'(e.idx));
        chk("timeout", int'(timeout), int'(e.to));
        chk("plu_err", int'(plu_err), 0);
        chk("plu_start_pulses", start_cnt, e.iters);
        chk("act_we_pulses", wb_cnt, e.iters);
        @(posedge clk); #1;
        chk("idle_after_done", int'({busy, done}), 0);
        chk("result_hold", int'(iter_cnt), e.iters);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{4'b0100, 4'b0100, 4'b0100, 0,  1'b1, 2'd2, 1'b0};
        vecs[1] = '{4'b1111, 4'b0110, 4'b0010, 2,  1'b1, 2'd1, 1'b0};
        vecs[2] = '{4'b1111, 4'b0000, 4'b0000, 1,  1'b0, 2'd0, 1'b0};
        vecs[3] = '{4'b0011, 4'b0011, 4'b0011, 15, 1'b0, 2'd0, 1'b1};
        vecs[4] = '{4'b0000, 4'b0000, 4'b0000, 0,  1'b0, 2'd0, 1'b0};
        vecs[5] = '{4'b1000, 4'b1000, 4'b1000, 0,  1'b1, 2'd3, 1'b0};
        vecs[6] = '{4'b0001, 4'b0001, 4'b0001, 0,  1'b1, 2'd0, 1'b0};
        vecs[7] = '{4'b1010, 4'b1000, 4'b1000, 1,  1'b1, 2'd3, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", all_out(), 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", int'(busy), 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset in the middle of a run
        cur_f0 = 4'b1111; cur_f1 = 4'b1111; cur_f2 = 4'b1111;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #1 chk("busy_mid_run", int'(busy), 1);
        chk("iter_mid_run", int'(iter_cnt), 2);
        @(negedge clk); #2 rst = 1'b0;
        #1 chk("async_reset_outputs", all_out(), 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("no_done_after_reset", int'({busy, done}), 0);
        run_vec(vecs[0]);

        // PLU never answers
        plu_en = 1'b0;
        cur_f0 = 4'b1111; cur_f1 = 4'b1111; cur_f2 = 4'b1111;
        start = 1'b1;
        begin
            int  n;
            bit  seen;
            n = 0; seen = 1'b0;
            for (int c = 1; c <= 200; c++) begin
                @(posedge clk); #1;
                if (c == 1) start = 1'b0;
                if (done) begin
                    seen = 1'b1; n = c;
                    break;
                end
            end
`ifdef MAXNET_SEQ_WDOG_EN
            chk("wdog_done_seen", int'(seen), 1);
            chk("wdog_latency", n, 68);
            chk("wdog_plu_err", int'(plu_err), 1);
            chk("wdog_valid_to", int'({winner_valid, timeout}), 0);
            @(posedge clk); #1;
            chk("wdog_idle", int'(busy), 0);
`else
            chk("nowdog_no_done", int'(seen), 0);
            chk("nowdog_busy", int'(busy), 1);
            chk("nowdog_plu_err", int'(plu_err), 0);
            @(negedge clk) rst = 1'b0;
            @(negedge clk) rst = 1'b1;
            @(posedge clk); #1;
`endif
        end
        plu_en = 1'b1;
        run_vec(vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
